// File: rtl/lnrv_icb2axi_if.sv
// ICB and AXI4 bus bundles used by the ICB-to-AXI bridge.
// The ICB bundle carries command and response channels.
// The AXI bundle carries the five single-beat AXI4 channels.

interface lnrv_icb_if #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32
);
    logic                        icb_cmd_vld;
    logic                        icb_cmd_rdy;
    logic                        icb_cmd_write;
    logic [P_ADDR_WIDTH-1:0]     icb_cmd_addr;
    logic [P_DATA_WIDTH-1:0]     icb_cmd_wdata;
    logic [P_DATA_WIDTH/8-1:0]   icb_cmd_wstrb;
    logic                        icb_rsp_vld;
    logic                        icb_rsp_rdy;
    logic                        icb_rsp_err;
    logic [P_DATA_WIDTH-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_vld, icb_cmd_write, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wstrb, icb_rsp_rdy,
        input  icb_cmd_rdy, icb_rsp_vld, icb_rsp_err, icb_rsp_rdata
    );
    modport slave (
        input  icb_cmd_vld, icb_cmd_write, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wstrb, icb_rsp_rdy,
        output icb_cmd_rdy, icb_rsp_vld, icb_rsp_err, icb_rsp_rdata
    );
endinterface

interface lnrv_axi_if #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32
);
    logic                        axi_awvalid;
    logic                        axi_awready;
    logic [P_ADDR_WIDTH-1:0]     axi_awaddr;
    logic [3:0]                  axi_awid;
    logic [7:0]                  axi_awlen;
    logic [2:0]                  axi_awsize;
    logic [1:0]                  axi_awburst;
    logic                        axi_awlock;
    logic [3:0]                  axi_awcache;
    logic [2:0]                  axi_awprot;
    logic                        axi_wvalid;
    logic                        axi_wready;
    logic [P_DATA_WIDTH-1:0]     axi_wdata;
    logic [P_DATA_WIDTH/8-1:0]   axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_bvalid;
    logic                        axi_bready;
    logic [1:0]                  axi_bresp;
    logic [3:0]                  axi_bid;
    logic                        axi_arvalid;
    logic                        axi_arready;
    logic [P_ADDR_WIDTH-1:0]     axi_araddr;
    logic [3:0]                  axi_arid;
    logic [7:0]                  axi_arlen;
    logic [2:0]                  axi_arsize;
    logic [1:0]                  axi_arburst;
    logic                        axi_arlock;
    logic [3:0]                  axi_arcache;
    logic [2:0]                  axi_arprot;
    logic                        axi_rvalid;
    logic                        axi_rready;
    logic [P_DATA_WIDTH-1:0]     axi_rdata;
    logic [1:0]                  axi_rresp;
    logic                        axi_rlast;
    logic [3:0]                  axi_rid;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
               axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
               axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid
    );
    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
               axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
               axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid
    );
endinterface

// File: rtl/lnrv_icb2axi.sv
// ICB slave to AXI4 master bridge. One command at a time is turned into a
// single-beat AXI transaction and its AXI response is returned as one ICB
// response. No bursts, no reordering, one outstanding transaction.

module lnrv_icb2axi #(
    parameter int         P_ADDR_WIDTH = 32,
    parameter int         P_DATA_WIDTH = 32,
    parameter logic [3:0] P_AXI_ID     = 4'h0
) (
    input  logic          clk,
    input  logic          reset,
    lnrv_icb_if.slave     icb,
    lnrv_axi_if.master    axi
);
    localparam int         LP_STRB_WIDTH = P_DATA_WIDTH / 8;
    localparam logic [2:0] LP_AXI_SIZE   = 3'($clog2(LP_STRB_WIDTH));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RSP  = 3'd2,
        RD_REQ  = 3'd3,
        RD_RSP  = 3'd4,
        ICB_RSP = 3'd5
    } state_t;

    state_t                      r_state;
    logic                        r_cmd_rdy;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_aw_done;
    logic                        r_w_done;
    logic                        r_bready;
    logic                        r_arvalid;
    logic                        r_rready;
    logic                        r_rsp_vld;
    logic                        r_rsp_err;
    logic [P_DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [P_ADDR_WIDTH-1:0]     r_addr;
    logic [P_DATA_WIDTH-1:0]     r_wdata;
    logic [LP_STRB_WIDTH-1:0]    r_wstrb;
    logic                        r_write;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_all;
    logic w_w_all;
    logic w_unused_ok;

    assign w_aw_hs  = r_awvalid & axi.axi_awready;
    assign w_w_hs   = r_wvalid & axi.axi_wready;
    assign w_aw_all = r_aw_done | w_aw_hs;
    assign w_w_all  = r_w_done | w_w_hs;

    // IDs, last flag of the read beat and the registered command direction
    // carry no information for a single outstanding single-beat transfer.
    assign w_unused_ok = ^{axi.axi_bid, axi.axi_rid, axi.axi_rlast, r_write};

    // Bridge state machine: every handshake output is a register updated on transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd_rdy   <= 1'b1;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (icb.icb_cmd_vld && r_cmd_rdy) begin
                        r_addr    <= icb.icb_cmd_addr;
                        r_wdata   <= icb.icb_cmd_wdata;
                        r_wstrb   <= icb.icb_cmd_wstrb;
                        r_write   <= icb.icb_cmd_write;
                        r_cmd_rdy <= 1'b0;
                        if (icb.icb_cmd_write) begin
                            r_state   <= WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state   <= RD_REQ;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    // Address and data channels complete independently, in any order.
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_state  <= WR_RSP;
                        r_bready <= 1'b1;
                    end
                end
                WR_RSP: begin
                    if (axi.axi_bvalid) begin
                        r_rsp_err   <= (axi.axi_bresp != 2'b00);
                        r_rsp_rdata <= '0;
                        r_bready    <= 1'b0;
                        r_rsp_vld   <= 1'b1;
                        r_state     <= ICB_RSP;
                    end
                end
                RD_REQ: begin
                    if (axi.axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    // EXOKAY counts as an error: exclusive accesses are never issued.
                    if (axi.axi_rvalid) begin
                        r_rsp_rdata <= axi.axi_rdata;
                        r_rsp_err   <= (axi.axi_rresp != 2'b00);
                        r_rready    <= 1'b0;
                        r_rsp_vld   <= 1'b1;
                        r_state     <= ICB_RSP;
                    end
                end
                ICB_RSP: begin
                    if (icb.icb_rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        r_cmd_rdy <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cmd_rdy <= 1'b1;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign icb.icb_cmd_rdy   = r_cmd_rdy;
    assign icb.icb_rsp_vld   = r_rsp_vld;
    assign icb.icb_rsp_err   = r_rsp_err;
    assign icb.icb_rsp_rdata = r_rsp_rdata;

    assign axi.axi_awvalid = r_awvalid;
    assign axi.axi_awaddr  = r_addr;
    assign axi.axi_awid    = P_AXI_ID;
    assign axi.axi_awlen   = 8'h00;
    assign axi.axi_awsize  = LP_AXI_SIZE;
    assign axi.axi_awburst = 2'b01;
    assign axi.axi_awlock  = 1'b0;
    assign axi.axi_awcache = 4'h0;
    assign axi.axi_awprot  = 3'b000;
    assign axi.axi_wvalid  = r_wvalid;
    assign axi.axi_wdata   = r_wdata;
    assign axi.axi_wstrb   = r_wstrb;
    assign axi.axi_wlast   = 1'b1;
    assign axi.axi_bready  = r_bready;
    assign axi.axi_arvalid = r_arvalid;
    assign axi.axi_araddr  = r_addr;
    assign axi.axi_arid    = P_AXI_ID;
    assign axi.axi_arlen   = 8'h00;
    assign axi.axi_arsize  = LP_AXI_SIZE;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_arlock  = 1'b0;
    assign axi.axi_arcache = 4'h0;
    assign axi.axi_arprot  = 3'b000;
    assign axi.axi_rready  = r_rready;

endmodule

// File: tb/tb_lnrv_icb2axi.sv
// Directed bench for the ICB-to-AXI bridge with a hand-driven AXI slave.

module tb_lnrv_icb2axi;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    lnrv_icb_if #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) icb ();
    lnrv_axi_if #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) axi ();

    lnrv_icb2axi #(
        .P_ADDR_WIDTH(32),
        .P_DATA_WIDTH(32),
        .P_AXI_ID(4'h0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .icb   (icb.slave),
        .axi   (axi.master)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic put_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        icb.icb_cmd_vld   = 1'b1;
        icb.icb_cmd_write = wr;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = d;
        icb.icb_cmd_wstrb = s;
    endtask

    // Write with independent AW/W ready delays (cycles after valid rises).
    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] br,
                          input logic exp_err, input string tag);
        int last;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        put_cmd(1'b1, a, d, s);
        tick();
        icb.icb_cmd_vld = 1'b0;
        for (int k = 0; k <= last; k++) begin
            chk({tag, ".awvalid"}, 64'(axi.axi_awvalid), 64'(k <= aw_dly));
            chk({tag, ".wvalid"},  64'(axi.axi_wvalid),  64'(k <= w_dly));
            chk({tag, ".bready_early"}, 64'(axi.axi_bready), 64'd0);
            chk({tag, ".cmd_rdy_busy"}, 64'(icb.icb_cmd_rdy), 64'd0);
            if (k <= aw_dly) chk({tag, ".awaddr"}, 64'(axi.axi_awaddr), 64'(a));
            if (k <= w_dly) begin
                chk({tag, ".wdata"}, 64'(axi.axi_wdata), 64'(d));
                chk({tag, ".wstrb"}, 64'(axi.axi_wstrb), 64'(s));
            end
            axi.axi_awready = (k == aw_dly);
            axi.axi_wready  = (k == w_dly);
            tick();
        end
        axi.axi_awready = 1'b0;
        axi.axi_wready  = 1'b0;
        chk({tag, ".bready"},     64'(axi.axi_bready),  64'd1);
        chk({tag, ".awvalid_lo"}, 64'(axi.axi_awvalid), 64'd0);
        chk({tag, ".wvalid_lo"},  64'(axi.axi_wvalid),  64'd0);
        axi.axi_bvalid = 1'b1;
        axi.axi_bresp  = br;
        tick();
        axi.axi_bvalid = 1'b0;
        axi.axi_bresp  = 2'b00;
        chk({tag, ".rsp_vld"},   64'(icb.icb_rsp_vld),   64'd1);
        chk({tag, ".rsp_err"},   64'(icb.icb_rsp_err),   64'(exp_err));
        chk({tag, ".rsp_rdata"}, 64'(icb.icb_rsp_rdata), 64'd0);
        chk({tag, ".bready_lo"}, 64'(axi.axi_bready),    64'd0);
        icb.icb_rsp_rdy = 1'b1;
        tick();
        icb.icb_rsp_rdy = 1'b0;
        chk({tag, ".rsp_done"}, 64'(icb.icb_rsp_vld), 64'd0);
        chk({tag, ".cmd_rdy"},  64'(icb.icb_cmd_rdy), 64'd1);
    endtask

    // Read with AR ready delay; optionally hold the ICB response off with a new write pending.
    task automatic rd_txn(input logic [31:0] a, input int ar_dly, input logic [31:0] rd,
                          input logic [1:0] rr, input logic exp_err, input int rsp_dly,
                          input logic pend, input string tag);
        put_cmd(1'b0, a, 32'h0, 4'h0);
        tick();
        icb.icb_cmd_vld = 1'b0;
        for (int k = 0; k <= ar_dly; k++) begin
            chk({tag, ".arvalid"}, 64'(axi.axi_arvalid), 64'd1);
            chk({tag, ".araddr"},  64'(axi.axi_araddr),  64'(a));
            chk({tag, ".rready_early"}, 64'(axi.axi_rready), 64'd0);
            axi.axi_arready = (k == ar_dly);
            tick();
        end
        axi.axi_arready = 1'b0;
        chk({tag, ".rready"},     64'(axi.axi_rready),  64'd1);
        chk({tag, ".arvalid_lo"}, 64'(axi.axi_arvalid), 64'd0);
        axi.axi_rvalid = 1'b1;
        axi.axi_rdata  = rd;
        axi.axi_rresp  = rr;
        tick();
        axi.axi_rvalid = 1'b0;
        axi.axi_rdata  = 32'hFFFF_FFFF;
        axi.axi_rresp  = 2'b00;
        for (int k = 0; k < rsp_dly; k++) begin
            if (pend) put_cmd(1'b1, 32'hA000_0000, 32'h5555_AAAA, 4'h3);
            chk({tag, ".hold_vld"},     64'(icb.icb_rsp_vld),   64'd1);
            chk({tag, ".hold_rdata"},   64'(icb.icb_rsp_rdata), 64'(rd));
            chk({tag, ".hold_err"},     64'(icb.icb_rsp_err),   64'(exp_err));
            chk({tag, ".hold_cmd_rdy"}, 64'(icb.icb_cmd_rdy),   64'd0);
            chk({tag, ".hold_awvalid"}, 64'(axi.axi_awvalid),   64'd0);
            tick();
        end
        chk({tag, ".rsp_vld"},   64'(icb.icb_rsp_vld),   64'd1);
        chk({tag, ".rsp_rdata"}, 64'(icb.icb_rsp_rdata), 64'(rd));
        chk({tag, ".rsp_err"},   64'(icb.icb_rsp_err),   64'(exp_err));
        chk({tag, ".rready_lo"}, 64'(axi.axi_rready),    64'd0);
        icb.icb_rsp_rdy = 1'b1;
        tick();
        icb.icb_rsp_rdy = 1'b0;
        chk({tag, ".rsp_done"}, 64'(icb.icb_rsp_vld), 64'd0);
        chk({tag, ".cmd_rdy"},  64'(icb.icb_cmd_rdy), 64'd1);
    endtask

    // Directed sequence.
    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        icb.icb_cmd_vld   = 1'b0;
        icb.icb_cmd_write = 1'b0;
        icb.icb_cmd_addr  = 32'h0;
        icb.icb_cmd_wdata = 32'h0;
        icb.icb_cmd_wstrb = 4'h0;
        icb.icb_rsp_rdy   = 1'b0;
        axi.axi_awready = 1'b0;
        axi.axi_wready  = 1'b0;
        axi.axi_bvalid  = 1'b0;
        axi.axi_bresp   = 2'b00;
        axi.axi_bid     = 4'h0;
        axi.axi_arready = 1'b0;
        axi.axi_rvalid  = 1'b0;
        axi.axi_rdata   = 32'h0;
        axi.axi_rresp   = 2'b00;
        axi.axi_rlast   = 1'b1;
        axi.axi_rid     = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        // Stray B/R valids while idle must not be acknowledged.
        axi.axi_bvalid = 1'b1;
        axi.axi_rvalid = 1'b1;
        tick();
        chk("rst.cmd_rdy", 64'(icb.icb_cmd_rdy),   64'd1);
        chk("rst.awvalid", 64'(axi.axi_awvalid),   64'd0);
        chk("rst.wvalid",  64'(axi.axi_wvalid),    64'd0);
        chk("rst.arvalid", 64'(axi.axi_arvalid),   64'd0);
        chk("rst.bready",  64'(axi.axi_bready),    64'd0);
        chk("rst.rready",  64'(axi.axi_rready),    64'd0);
        chk("rst.rsp_vld", 64'(icb.icb_rsp_vld),   64'd0);
        chk("rst.rsp_err", 64'(icb.icb_rsp_err),   64'd0);
        chk("rst.rdata",   64'(icb.icb_rsp_rdata), 64'd0);
        chk("rst.awaddr",  64'(axi.axi_awaddr),    64'd0);
        chk("rst.wdata",   64'(axi.axi_wdata),     64'd0);
        chk("rst.wstrb",   64'(axi.axi_wstrb),     64'd0);
        chk("const.awlen",   64'(axi.axi_awlen),   64'd0);
        chk("const.awsize",  64'(axi.axi_awsize),  64'd2);
        chk("const.arsize",  64'(axi.axi_arsize),  64'd2);
        chk("const.awburst", 64'(axi.axi_awburst), 64'd1);
        chk("const.wlast",   64'(axi.axi_wlast),   64'd1);
        chk("const.awid",    64'(axi.axi_awid),    64'd0);
        axi.axi_bvalid = 1'b0;
        axi.axi_rvalid = 1'b0;

        wr_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1'b0, "wr0");
        rd_txn(32'h1000_0004, 0, 32'h1234_5678, 2'b00, 1'b0, 0, 1'b0, "rd0");
        wr_txn(32'h2000_0020, 32'hCAFE_F00D, 4'h5, 0, 3, 2'b00, 1'b0, "wr_wlate");
        wr_txn(32'h2000_0024, 32'h0BAD_CAFE, 4'hA, 3, 0, 2'b00, 1'b0, "wr_awlate");
        rd_txn(32'h3000_0008, 2, 32'h8765_4321, 2'b10, 1'b1, 0, 1'b0, "rd_slverr");
        wr_txn(32'h3000_000C, 32'h1111_2222, 4'h1, 1, 1, 2'b11, 1'b1, "wr_decerr");
        rd_txn(32'h3000_0010, 0, 32'h0F0F_0F0F, 2'b01, 1'b1, 0, 1'b0, "rd_exokay");
        rd_txn(32'h4000_0000, 0, 32'hA5A5_5A5A, 2'b00, 1'b0, 5, 1'b1, "rd_hold");
        wr_txn(32'hA000_0000, 32'h5555_AAAA, 4'h3, 0, 0, 2'b00, 1'b0, "wr_pend");

        // Reset in WR_REQ with awvalid high.
        put_cmd(1'b1, 32'h5000_0000, 32'h7777_7777, 4'hF);
        tick();
        icb.icb_cmd_vld = 1'b0;
        chk("mid.awvalid_pre", 64'(axi.axi_awvalid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid.awvalid", 64'(axi.axi_awvalid), 64'd0);
        chk("mid.wvalid",  64'(axi.axi_wvalid),  64'd0);
        chk("mid.arvalid", 64'(axi.axi_arvalid), 64'd0);
        chk("mid.bready",  64'(axi.axi_bready),  64'd0);
        chk("mid.rsp_vld", 64'(icb.icb_rsp_vld), 64'd0);
        chk("mid.cmd_rdy", 64'(icb.icb_cmd_rdy), 64'd1);
        rd_txn(32'h6000_0004, 0, 32'h0000_ABCD, 2'b00, 1'b0, 0, 1'b0, "rd_post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lnrv_icb2axi.md
# lnrv_icb2axi

ICB-slave to AXI4-master bridge: accepts one ICB command at a time and issues it on AXI4 as a single-beat transaction. It then returns the AXI response as one ICB response. It lets ICB-native masters (core LSU, debug module) reach AXI-attached memories and peripherals. It is the counterpart of the AXI-to-ICB bridge already in the bus directory. At most one transaction is outstanding; there are no bursts and no reordering.

## Interface
- P_ADDR_WIDTH, 32, address width on both sides
- P_DATA_WIDTH, 32, data width on both sides (32 or 64); strobe width P_DATA_WIDTH/8
- P_AXI_ID, 4'h0, constant driven on axi_awid/axi_arid
- clk  input  1  single clock; everything is rising-edge
- reset  input  1  synchronous, active-high
- icb_cmd_vld / icb_cmd_rdy  input / output  1  ICB command handshake
- icb_cmd_write  input  1  1 = write, 0 = read
- icb_cmd_addr  input  P_ADDR_WIDTH  byte address
- icb_cmd_wdata / icb_cmd_wstrb  input  P_DATA_WIDTH / P_DATA_WIDTH/8  write data and byte strobes
- icb_rsp_vld / icb_rsp_rdy  output / input  1  ICB response handshake
- icb_rsp_err  output  1  AXI response was not OKAY
- icb_rsp_rdata  output  P_DATA_WIDTH  read data; 0 for writes
- axi_awvalid / axi_awready, axi_arvalid / axi_arready  output / input  1  address handshakes
- axi_awaddr / axi_araddr  output  P_ADDR_WIDTH  registered command address
- axi_awid / axi_arid  output  4  P_AXI_ID
- axi_awlen / axi_arlen  output  8  constant 0 (single beat)
- axi_awsize / axi_arsize  output  3  constant log2(P_DATA_WIDTH/8)
- axi_awburst / axi_arburst  output  2  constant 2'b01 (INCR)
- axi_awlock / axi_arlock, axi_awcache / axi_arcache, axi_awprot / axi_arprot  output  1 / 4 / 3  constant 0
- axi_wvalid / axi_wready  output / input  1  write-data handshake
- axi_wdata / axi_wstrb  output  P_DATA_WIDTH / P_DATA_WIDTH/8  registered write data and strobes
- axi_wlast  output  1  constant 1
- axi_bvalid / axi_bready  input / output  1; axi_bresp  input  2; axi_bid  input  4 (ignored)
- axi_rvalid / axi_rready  input / output  1; axi_rdata  input  P_DATA_WIDTH; axi_rresp  input  2; axi_rlast, axi_rid  input (ignored)

## Operation
- States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, ICB_RSP.
- IDLE: icb_cmd_rdy = 1, driven from state only. On vld&rdy the block latches addr, wdata, wstrb and write, then moves to WR_REQ or RD_REQ.
- WR_REQ: axi_awvalid and axi_wvalid are asserted together.
  - Each deasserts independently after its own handshake; flags aw_done and w_done track this.
  - The block moves to WR_RSP in the cycle both are done. Same-cycle handshakes and either order are legal.
- WR_RSP: axi_bready = 1. On bvalid the block captures err = (bresp != 2'b00), clears rdata and moves to ICB_RSP.
- RD_REQ: axi_arvalid = 1. On arready it moves to RD_RSP.
- RD_RSP: axi_rready = 1. On rvalid it captures rdata and err = (rresp != 2'b00), then moves to ICB_RSP.
- ICB_RSP: icb_rsp_vld = 1, with err and rdata held stable. On icb_rsp_rdy it returns to IDLE.
- AXI valids never drop before their ready; address and data stay stable while valid.
- EXOKAY (2'b01) is reported as error, because exclusive access is not issued.

## Timing
- Reset values: all AXI valids, readies and icb_rsp_vld are 0. icb_cmd_rdy is 1 (IDLE). icb_rsp_err is 0, icb_rsp_rdata is 0, and the registered addr/data/strb are 0.
- Command accepted at edge N: AXI valid(s) are high in cycle N+1.
- Zero-wait AXI slave: ready in N+1 and response in N+2 give icb_rsp_vld in N+3.
- With icb_rsp_rdy = 1, icb_cmd_rdy is high again in N+4. Peak throughput is one transaction per 4 cycles.
- icb_cmd_rdy = 0 in every state except IDLE. A command presented then is held off and not lost.
- Extra AXI bvalid or rvalid outside WR_RSP/RD_RSP is not acknowledged (ready = 0).
- Reset mid-transaction returns to IDLE next edge with all valids low. The AXI slave must be reset together with this block.

## Test plan
- Write 0x8000_0010 / 0xDEAD_BEEF / strb 4'hF, zero-wait slave -> AW and W at N+1, awlen 0, awsize 2, wlast 1; bresp 0 -> icb_rsp_vld at N+3, err 0, rdata 0.
- Read 0x1000_0004, slave returns rdata 0x1234_5678, rresp 0 -> arvalid at N+1, icb_rsp_vld at N+3, rdata 0x1234_5678, err 0.
- Write where wready comes 3 cycles after awready (then the reverse) -> each valid drops only after its own handshake; bready is asserted only after both; response is correct.
- Read with rresp 2'b10 and write with bresp 2'b11 -> icb_rsp_err 1 for each.
- icb_rsp_rdy held low 5 cycles with a new command pending -> rsp_vld and data stable, cmd_rdy 0, new command accepted the cycle after ICB_RSP exits.
- Reset asserted in WR_REQ with awvalid high -> next cycle all valids 0, icb_cmd_rdy 1; a following read completes normally.
